// File: rtl/ex_pkg.sv
// Shared types for the EX stage: ALU opcodes, forwarding selects,
// branch funct3 codes and the EX/MEM pipeline register payload.
package ex_pkg;

  localparam int unsigned EX_XLEN = 32;
  localparam int unsigned REG_AW  = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // EX/MEM register contents
  typedef struct packed {
    logic                 ins_n_vld;
    logic                 rd_wren;
    logic                 mem_wren;
    logic [EX_XLEN-1:0]   pc_4;
    logic [EX_XLEN-1:0]   alu_data;
    logic [EX_XLEN-1:0]   rs2_data;
    logic [1:0]           wb_sel;
    logic [2:0]           slt_sl;
    logic [REG_AW-1:0]    rd_addr;
  } ex_mem_t;

endpackage

// File: rtl/ex_cycle_if.sv
// EX/MEM bus carrying the registered *_M fields into mem_cycle.
// master: ex_cycle (drives), slave: mem_cycle (consumes).
interface ex_cycle_if;
  import ex_pkg::*;

  logic                 o_ins_n_vld_M;
  logic                 o_rd_wren_M;
  logic                 o_mem_wren_M;
  logic [EX_XLEN-1:0]   o_pc_4_M;
  logic [EX_XLEN-1:0]   o_alu_data_M;
  logic [EX_XLEN-1:0]   o_rs2_data_M;
  logic [1:0]           o_wb_sel_M;
  logic [2:0]           o_slt_sl_M;
  logic [REG_AW-1:0]    o_rd_addr_M;

  modport master (
    output o_ins_n_vld_M, o_rd_wren_M, o_mem_wren_M, o_pc_4_M,
           o_alu_data_M, o_rs2_data_M, o_wb_sel_M, o_slt_sl_M, o_rd_addr_M
  );

  modport slave (
    input  o_ins_n_vld_M, o_rd_wren_M, o_mem_wren_M, o_pc_4_M,
           o_alu_data_M, o_rs2_data_M, o_wb_sel_M, o_slt_sl_M, o_rd_addr_M
  );

endinterface

// File: rtl/alu.sv
// RV32I integer ALU, purely combinational.
// Ports: a, b operands; op ALU opcode; result (0 for undefined opcodes).
module alu
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << shamt;
      ALU_SLT:   result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU:  result = XLEN'(a < b);
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ex_cycle.sv
// Execute stage: operand forwarding, ALU, branch comparator, PC redirect
// and the EX/MEM pipeline register.
// Ports: i_clk/i_rst_M (async, active-high); i_enb_M hold, i_flush_M bubble;
// *_E decoded EX instruction fields; i_wb_data_W forwarding source;
// o_pc_sel_E/o_pc_target_E combinational redirect; m EX/MEM bus (registered).
module ex_cycle
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_M,
  input  logic            i_enb_M,
  input  logic            i_flush_M,
  input  logic            i_ins_n_vld_E,
  input  logic [XLEN-1:0] i_pc_E,
  input  logic [XLEN-1:0] i_pc_4_E,
  input  logic [XLEN-1:0] i_rs1_data_E,
  input  logic [XLEN-1:0] i_rs2_data_E,
  input  logic [XLEN-1:0] i_imm_E,
  input  logic [4:0]      i_rd_addr_E,
  input  logic            i_rd_wren_E,
  input  logic            i_mem_wren_E,
  input  logic [1:0]      i_wb_sel_E,
  input  logic [2:0]      i_slt_sl_E,
  input  logic [3:0]      i_alu_op_E,
  input  logic            i_opa_sel_E,
  input  logic            i_opb_sel_E,
  input  logic            i_br_E,
  input  logic            i_jmp_E,
  input  logic [2:0]      i_br_f3_E,
  input  logic [1:0]      i_fwd_a_sel_E,
  input  logic [1:0]      i_fwd_b_sel_E,
  input  logic [XLEN-1:0] i_wb_data_W,
  output logic            o_pc_sel_E,
  output logic [XLEN-1:0] o_pc_target_E,
  ex_cycle_if.master      m
);

  ex_mem_t         q;
  ex_mem_t         d;
  logic [XLEN-1:0] fa;
  logic [XLEN-1:0] fb;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic            taken;

  // Forwarding muxes; the unused select code falls back to the register file
  always_comb begin
    case (fwd_sel_e'(i_fwd_a_sel_E))
      FWD_MEM: fa = q.alu_data;
      FWD_WB:  fa = i_wb_data_W;
      default: fa = i_rs1_data_E;
    endcase
    case (fwd_sel_e'(i_fwd_b_sel_E))
      FWD_MEM: fb = q.alu_data;
      FWD_WB:  fb = i_wb_data_W;
      default: fb = i_rs2_data_E;
    endcase
  end

  assign op_a = i_opa_sel_E ? i_pc_E  : fa;
  assign op_b = i_opb_sel_E ? i_imm_E : fb;

  alu #(.XLEN(XLEN)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (alu_op_e'(i_alu_op_E)),
    .result (alu_res)
  );

  // Branch comparator works on forwarded register values, not on the ALU operands
  always_comb begin
    taken = 1'b0;
    case (i_br_f3_E)
      F3_BEQ:  taken = (fa == fb);
      F3_BNE:  taken = (fa != fb);
      F3_BLT:  taken = ($signed(fa) < $signed(fb));
      F3_BGE:  taken = ($signed(fa) >= $signed(fb));
      F3_BLTU: taken = (fa < fb);
      F3_BGEU: taken = (fa >= fb);
      default: taken = 1'b0;
    endcase
  end

  assign o_pc_sel_E    = i_ins_n_vld_E & (i_jmp_E | (i_br_E & taken));
  assign o_pc_target_E = {alu_res[XLEN-1:1], 1'b0};

  // Next EX/MEM contents; a flush only kills the control bits
  always_comb begin
    d.ins_n_vld = i_ins_n_vld_E & ~i_flush_M;
    d.rd_wren   = i_rd_wren_E   & ~i_flush_M;
    d.mem_wren  = i_mem_wren_E  & ~i_flush_M;
    d.pc_4      = i_pc_4_E;
    d.alu_data  = alu_res;
    d.rs2_data  = fb;
    d.wb_sel    = i_wb_sel_E;
    d.slt_sl    = i_slt_sl_E;
    d.rd_addr   = i_rd_addr_E;
  end

  // EX/MEM register: reset, then hold, then capture (flush folded into d)
  always_ff @(posedge i_clk or posedge i_rst_M) begin
    if (i_rst_M) begin
      q <= '0;
    end else if (!i_enb_M) begin
      q <= d;
    end
  end

  assign m.o_ins_n_vld_M = q.ins_n_vld;
  assign m.o_rd_wren_M   = q.rd_wren;
  assign m.o_mem_wren_M  = q.mem_wren;
  assign m.o_pc_4_M      = q.pc_4;
  assign m.o_alu_data_M  = q.alu_data;
  assign m.o_rs2_data_M  = q.rs2_data;
  assign m.o_wb_sel_M    = q.wb_sel;
  assign m.o_slt_sl_M    = q.slt_sl;
  assign m.o_rd_addr_M   = q.rd_addr;

endmodule
